uart_echo_ctrl: RTL and testbench

// Sequencer between the UART receiver (byte + 1-cycle valid strobe) and the UART

---
 rtl/uart_echo_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_echo_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// Echo sequencer: buffers bytes from the UART RX strobe in a FIFO and replays them to the
// UART TX one at a time, optionally expanding CR into CR LF. fsm_state exposes the FSM.
module uart_echo_ctrl #(
  parameter int DEPTH       = 16,
  parameter bit CRLF_EN     = 1'b1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     echo_en,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [1:0]               fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, SEND_LF} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last_cr, last_cr_n;
  logic            lf_done, lf_done_n;
  logic            full, empty, push, pop, launch, finish;
  logic [7:0]      head, launch_byte;

  // Handshake: rx_valid is a 1-cycle strobe with no back-pressure (dropped when full);
  // tx_start is a 1-cycle launch, tx_busy rising acknowledges it, tx_busy falling completes it.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = rx_valid && !full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;
  assign fsm_state  = state;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    launch      = 1'b0;
    launch_byte = head;
    last_cr_n   = last_cr;
    lf_done_n   = lf_done;
    cnt_n       = cnt;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && echo_en && !tx_busy) begin
          pop       = 1'b1;
          launch    = 1'b1;
          last_cr_n = (head == 8'h0D);
          cnt_n     = '0;
          state_n   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_n = WAIT_DONE;
        else if (cnt == CW'(ACK_TIMEOUT - 1)) finish = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) finish = 1'b1;
      end
      SEND_LF: begin
        launch      = 1'b1;
        launch_byte = 8'h0A;
        lf_done_n   = 1'b1;
        last_cr_n   = 1'b0;
        cnt_n       = '0;
        state_n     = WAIT_ACK;
      end
      default: state_n = IDLE;
    endcase
    // A timed-out acknowledge completes exactly like a normal busy fall.
    if (finish) begin
      if (CRLF_EN && last_cr && !lf_done) begin
        state_n = SEND_LF;
      end else begin
        state_n   = IDLE;
        lf_done_n = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_cr  <= 1'b0;
      lf_done  <= 1'b0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_cr  <= last_cr_n;
      lf_done  <= lf_done_n;
      tx_start <= launch;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && full) overflow <= 1'b1;
      if (launch) tx_data <= launch_byte;
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl: a busy-flag TX model, a logged TX byte stream
// compared against an expected queue, and a second instance without CR LF expansion.
module tb_uart_echo_ctrl;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 64;
  localparam int BUSY_LEN    = 10;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       echo_en;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       overflow;
  logic [1:0] fsm_state;

  logic [7:0] nl_tx_data;
  logic       nl_tx_start;
  logic [$clog2(DEPTH):0] nl_fifo_level;
  logic       nl_overflow;
  logic [1:0] nl_fsm_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit busy_en = 1'b0;
  int busy_left = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] nolf_log[$];
  int start_cyc[$];

  uart_echo_ctrl #(.DEPTH(DEPTH), .CRLF_EN(1'b1), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .echo_en(echo_en),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .fifo_level(fifo_level),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  uart_echo_ctrl #(.DEPTH(DEPTH), .CRLF_EN(1'b0), .ACK_TIMEOUT(4)) dut_nolf (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .echo_en(echo_en),
    .tx_busy(1'b0), .tx_data(nl_tx_data), .tx_start(nl_tx_start), .fifo_level(nl_fifo_level),
    .overflow(nl_overflow), .fsm_state(nl_fsm_state)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // TX model: log launches, raise tx_busy for BUSY_LEN cycles after each tx_start
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_start === 1'b1) begin
        tx_log.push_back(tx_data);
        start_cyc.push_back(cyc);
        if (busy_en) busy_left = BUSY_LEN;
      end
      if (nl_tx_start === 1'b1) nolf_log.push_back(nl_tx_data);
      if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    nolf_log.delete();
    start_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    busy_left = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    clear_logs();
  endtask

  // Called at a negedge; consecutive calls give back-to-back strobes.
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      if (fsm_state == 2'd0 && fifo_level == 0 && tx_busy == 1'b0) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), tx_log[i], exp_q[i]);
  endtask

  initial begin
    int c0;
    bit seen;
    echo_en = 1'b1;
    busy_en = 1'b1;
    do_reset();

    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_state", fsm_state, 2'd0);

    // Single byte with 2-cycle launch latency
    c0 = cyc;
    push_byte(8'h41);
    check_eq("t1_level_push", fifo_level, 1);
    check_eq("t1_start_early", tx_start, 1'b0);
    @(negedge CLK);
    check_eq("t1_start", tx_start, 1'b1);
    check_eq("t1_level_pop", fifo_level, 0);
    check_eq("t1_state_ack", fsm_state, 2'd1);
    wait_drained(60, "t1_drain");
    exp_q = '{8'h41};
    check_log("t1");
    if (start_cyc.size() > 0) check_eq("t1_latency", start_cyc[0] - c0, 2);
    else check_eq("t1_latency_missing", 0, 1);

    // CR expansion vs. no expansion
    repeat (10) @(negedge CLK);
    clear_logs();
    push_byte(8'h0D);
    push_byte(8'h42);
    wait_drained(150, "t2_drain");
    exp_q = '{8'h0D, 8'h0A, 8'h42};
    check_log("t2");
    check_eq("t2_nolf_count", nolf_log.size(), 2);
    if (nolf_log.size() == 2) begin
      check_eq("t2_nolf_b0", nolf_log[0], 8'h0D);
      check_eq("t2_nolf_b1", nolf_log[1], 8'h42);
    end
    check_eq("t2_overflow", overflow, 1'b0);

    // Overflow with launches blocked, then drain in order
    do_reset();
    echo_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    check_eq("t3_level_full", fifo_level, DEPTH);
    check_eq("t3_no_ovf_yet", overflow, 1'b0);
    push_byte(8'hE1);
    push_byte(8'hE2);
    check_eq("t3_level_still_full", fifo_level, DEPTH);
    check_eq("t3_overflow", overflow, 1'b1);
    check_eq("t3_nothing_sent", tx_log.size(), 0);
    echo_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h10 + 8'(i));
    wait_drained(400, "t3_drain");
    check_log("t3");
    check_eq("t3_overflow_sticky", overflow, 1'b1);

    // Push on a full FIFO in the same cycle as a pop is dropped
    do_reset();
    echo_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'hA0 + 8'(i));
    check_eq("t4_ovf_before", overflow, 1'b0);
    echo_en = 1'b1;
    push_byte(8'hEE);
    check_eq("t4_level", fifo_level, DEPTH - 1);
    check_eq("t4_overflow", overflow, 1'b1);
    check_eq("t4_popped", tx_start, 1'b1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hA0 + 8'(i));
    wait_drained(400, "t4_drain");
    check_log("t4");

    // Acknowledge timeout with tx_busy stuck low
    do_reset();
    busy_en = 1'b0;
    push_byte(8'h55);
    push_byte(8'h66);
    repeat (30) @(negedge CLK);
    check_eq("t5_state_wait_ack", fsm_state, 2'd1);
    wait_drained(250, "t5_drain");
    exp_q = '{8'h55, 8'h66};
    check_log("t5");
    if (start_cyc.size() == 2) check_eq("t5_gap", start_cyc[1] - start_cyc[0], ACK_TIMEOUT + 1);
    else check_eq("t5_gap_missing", start_cyc.size(), 2);

    // Async reset during WAIT_DONE with 3 bytes queued
    busy_en = 1'b1;
    do_reset();
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    push_byte(8'h34);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fsm_state == 2'd2) seen = 1'b1;
      else @(negedge CLK);
    end
    check_eq("t6_in_wait_done", 32'(seen), 32'd1);
    check_eq("t6_queued", fifo_level, 3);
    check_eq("t6_tx_data_before", tx_data, 8'h31);
    #2 RST = 1'b1;
    #1;
    check_eq("t6_async_tx_data", tx_data, 8'h00);
    check_eq("t6_async_tx_start", tx_start, 1'b0);
    check_eq("t6_async_level", fifo_level, 0);
    check_eq("t6_async_state", fsm_state, 2'd0);
    busy_left = 0;
    @(negedge CLK);
    RST = 1'b0;
    clear_logs();
    repeat (40) @(negedge CLK);
    check_eq("t6_quiet", tx_log.size(), 0);
    push_byte(8'h77);
    wait_drained(60, "t6_drain");
    exp_q = '{8'h77};
    check_log("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
